uart_avm_scheduler: RTL and testbench

Avalon-MM master that owns the Qsys UART core's register port and shares it between two byte-stream transmit requesters and one receive consumer. It polls the UART status register, drains received bytes first, then grants transmit slots round-robin. It sits beside the `sw_qsys` instance on the DE2_115 top, between user logic and the UART's Avalon-MM slave.

---
 rtl/uart_avm_scheduler.sv | 151 +++++++++++++++
 tb/tb_uart_avm_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_avm_scheduler.sv
// Avalon-MM master that owns the UART register port. It polls the status
// register, drains received bytes first, then shares the transmit holding
// register between two byte-stream requesters using round-robin arbitration.
module uart_avm_scheduler #(
  parameter logic [4:0] RX_ADDR     = 5'd0,
  parameter logic [4:0] TX_ADDR     = 5'd4,
  parameter logic [4:0] STATUS_ADDR = 5'd8,
  parameter int         RRDY_BIT    = 7,
  parameter int         TRDY_BIT    = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [4:0]  o_avm_address,
  output logic        o_avm_read,
  output logic        o_avm_write,
  output logic [31:0] o_avm_writedata,
  input  logic [31:0] i_avm_readdata,
  input  logic        i_avm_waitrequest,
  input  logic [7:0]  i_tx0_data,
  input  logic [7:0]  i_tx1_data,
  input  logic        i_tx0_valid,
  input  logic        i_tx1_valid,
  output logic        o_tx0_ready,
  output logic        o_tx1_ready,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_valid,
  input  logic        i_rx_ready,
  output logic        o_last_grant
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STATUS,
    S_DECIDE,
    S_RX_READ,
    S_TX_WRITE
  } state_t;

  state_t      state_q;
  logic [31:0] status_q;
  logic [4:0]  addr_q;
  logic        read_q;
  logic        write_q;
  logic [7:0]  wbyte_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        last_grant_q;

  // Decision-cycle terms: rx has priority, tx1 wins only when alone or when
  // tx0 had the previous grant.
  logic rx_want_d;
  logic tx_go_d;
  logic pick1_d;
  logic unused_status;

  // Grant and ready decode for the single S_DECIDE cycle.
  always_comb begin
    rx_want_d = status_q[RRDY_BIT] & ~rx_valid_q;
    pick1_d   = i_tx1_valid & (~i_tx0_valid | ~last_grant_q);
    tx_go_d   = (state_q == S_DECIDE) & ~rx_want_d & status_q[TRDY_BIT] &
                (i_tx0_valid | i_tx1_valid);
  end

  // Whole status word is latched; only two bits steer the decision.
  assign unused_status = ^status_q;

  assign o_tx0_ready     = tx_go_d & ~pick1_d;
  assign o_tx1_ready     = tx_go_d & pick1_d;
  assign o_avm_address   = addr_q;
  assign o_avm_read      = read_q;
  assign o_avm_write     = write_q;
  assign o_avm_writedata = {24'd0, wbyte_q};
  assign o_rx_data       = rx_data_q;
  assign o_rx_valid      = rx_valid_q;
  assign o_last_grant    = last_grant_q;

  // Scheduler FSM; bus strobes and address are registered on entry to each state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      status_q     <= '0;
      addr_q       <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      wbyte_q      <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (rx_valid_q && i_rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          state_q <= S_STATUS;
          read_q  <= 1'b1;
          addr_q  <= STATUS_ADDR;
        end
        S_STATUS: begin
          if (!i_avm_waitrequest) begin
            status_q <= i_avm_readdata;
            state_q  <= S_DECIDE;
            read_q   <= 1'b0;
            addr_q   <= '0;
          end
        end
        S_DECIDE: begin
          if (rx_want_d) begin
            state_q <= S_RX_READ;
            read_q  <= 1'b1;
            addr_q  <= RX_ADDR;
          end else if (tx_go_d) begin
            state_q      <= S_TX_WRITE;
            write_q      <= 1'b1;
            addr_q       <= TX_ADDR;
            wbyte_q      <= pick1_d ? i_tx1_data : i_tx0_data;
            last_grant_q <= pick1_d;
          end else begin
            state_q <= S_STATUS;
            read_q  <= 1'b1;
            addr_q  <= STATUS_ADDR;
          end
        end
        S_RX_READ: begin
          if (!i_avm_waitrequest) begin
            rx_data_q  <= i_avm_readdata[7:0];
            rx_valid_q <= 1'b1;
            state_q    <= S_STATUS;
            read_q     <= 1'b1;
            addr_q     <= STATUS_ADDR;
          end
        end
        S_TX_WRITE: begin
          if (!i_avm_waitrequest) begin
            state_q <= S_STATUS;
            write_q <= 1'b0;
            read_q  <= 1'b1;
            addr_q  <= STATUS_ADDR;
          end
        end
        default: begin
          state_q <= S_IDLE;
          read_q  <= 1'b0;
          write_q <= 1'b0;
          addr_q  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_avm_scheduler.sv
// Directed bench for uart_avm_scheduler with a small Avalon slave model.
module tb_uart_avm_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        wreq = 1'b0;
  logic [7:0]  tx0_d = 8'h00, tx1_d = 8'h00;
  logic        tx0_v = 1'b0, tx1_v = 1'b0;
  logic        tx0_r, tx1_r;
  logic [7:0]  rx_d;
  logic        rx_v;
  logic        rx_r = 1'b0;
  logic        lg;

  logic [7:0]  status_v = 8'h00;
  logic [7:0]  rxbyte_v = 8'h00;

  int total = 0;
  int bad   = 0;

  // monitor state
  int       cyc = 0;
  int       wr_n, rx_rd_n, rdy0_n, rdy1_n, viol_n;
  logic [7:0] wr_d [16];
  int       wr_c [16];
  int       rx_rd_c;

  always #5 clk = ~clk;

  assign rdata = (addr == 5'd8) ? {24'd0, status_v} :
                 (addr == 5'd0) ? {24'd0, rxbyte_v} : 32'hDEAD_BEEF;

  uart_avm_scheduler dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .o_avm_address    (addr),
    .o_avm_read       (rd),
    .o_avm_write      (wr),
    .o_avm_writedata  (wdata),
    .i_avm_readdata   (rdata),
    .i_avm_waitrequest(wreq),
    .i_tx0_data       (tx0_d),
    .i_tx1_data       (tx1_d),
    .i_tx0_valid      (tx0_v),
    .i_tx1_valid      (tx1_v),
    .o_tx0_ready      (tx0_r),
    .o_tx1_ready      (tx1_r),
    .o_rx_data        (rx_d),
    .o_rx_valid       (rx_v),
    .i_rx_ready       (rx_r),
    .o_last_grant     (lg)
  );

  // Bus monitor: accepted transfers, ready pulses and protocol violations.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      wr_n = 0; rx_rd_n = 0; rdy0_n = 0; rdy1_n = 0; rx_rd_c = 0;
    end else begin
      if (wr && !wreq && wr_n < 16) begin
        wr_d[wr_n] = wdata[7:0];
        wr_c[wr_n] = cyc;
        wr_n = wr_n + 1;
      end
      if (rd && !wreq && addr == 5'd0) begin
        rx_rd_n = rx_rd_n + 1;
        rx_rd_c = cyc;
      end
      if (tx0_r) rdy0_n = rdy0_n + 1;
      if (tx1_r) rdy1_n = rdy1_n + 1;
    end
    if ((rd && wr) || (tx0_r && tx1_r) || (tx0_r && !tx0_v) || (tx1_r && !tx1_v))
      viol_n = viol_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    viol_n = 0;
    // ---------------- reset values
    tx0_d = 8'h41; tx0_v = 1'b1; status_v = 8'h40;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_read", {31'd0, rd}, 0);
    chk("rst_write", {31'd0, wr}, 0);
    chk("rst_addr", {27'd0, addr}, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_ready", {30'd0, tx0_r, tx1_r}, 0);
    chk("rst_rxv", {31'd0, rx_v}, 0);
    chk("rst_rxd", {24'd0, rx_d}, 0);
    chk("rst_lg", {31'd0, lg}, 1);
    rst = 1'b0;

    // ---------------- single tx0 byte
    @(negedge clk);
    chk("t1_stat_rd", {31'd0, rd}, 1);
    chk("t1_stat_addr", {27'd0, addr}, 8);
    @(negedge clk);
    chk("t1_decide_rd", {31'd0, rd}, 0);
    chk("t1_rdy0", {31'd0, tx0_r}, 1);
    @(negedge clk);
    chk("t1_wr", {31'd0, wr}, 1);
    chk("t1_addr", {27'd0, addr}, 4);
    chk("t1_wdata", wdata, 32'h41);
    chk("t1_lg", {31'd0, lg}, 0);
    chk("t1_rdy0_off", {31'd0, tx0_r}, 0);
    tx0_v = 1'b0;
    repeat (10) @(negedge clk);
    chk("t1_wr_n", wr_n, 1);
    chk("t1_rdy_n", rdy0_n, 1);
    chk("t1_byte", {24'd0, wr_d[0]}, 32'h41);

    // ---------------- round-robin alternation
    tx0_d = 8'hAA; tx1_d = 8'h55; tx0_v = 1'b1; tx1_v = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && wr_n < 4; i++) @(negedge clk);
    chk("t2_timeout", {31'd0, wr_n >= 4}, 1);
    chk("t2_b0", {24'd0, wr_d[0]}, 32'hAA);
    chk("t2_b1", {24'd0, wr_d[1]}, 32'h55);
    chk("t2_b2", {24'd0, wr_d[2]}, 32'hAA);
    chk("t2_b3", {24'd0, wr_d[3]}, 32'h55);
    chk("t2_gap1", wr_c[1] - wr_c[0], 3);
    chk("t2_gap3", wr_c[3] - wr_c[2], 3);
    tx0_v = 1'b0; tx1_v = 1'b0;

    // ---------------- rx first, then tx
    status_v = 8'hC0; rxbyte_v = 8'h5A; tx0_d = 8'h41; tx0_v = 1'b1; rx_r = 1'b0;
    do_reset();
    @(negedge clk);                       // S_STATUS
    @(negedge clk);                       // S_DECIDE
    chk("t3_no_rdy", {31'd0, tx0_r}, 0);
    @(negedge clk);                       // S_RX_READ
    chk("t3_rx_rd", {31'd0, rd}, 1);
    chk("t3_rx_addr", {27'd0, addr}, 0);
    chk("t3_rxv_pre", {31'd0, rx_v}, 0);
    @(negedge clk);
    chk("t3_rxv", {31'd0, rx_v}, 1);
    chk("t3_rxd", {24'd0, rx_d}, 32'h5A);
    for (int i = 0; i < 20 && wr_n < 1; i++) @(negedge clk);
    tx0_v = 1'b0;
    chk("t3_timeout", {31'd0, wr_n >= 1}, 1);
    chk("t3_wbyte", {24'd0, wr_d[0]}, 32'h41);
    chk("t3_rx_before", {31'd0, rx_rd_c < wr_c[0]}, 1);

    // ---------------- rx stalled does not block tx; release resumes rx
    tx1_d = 8'h77; tx1_v = 1'b1;
    for (int i = 0; i < 20 && wr_n < 2; i++) @(negedge clk);
    tx1_v = 1'b0;
    chk("t4_timeout", {31'd0, wr_n >= 2}, 1);
    chk("t4_wbyte", {24'd0, wr_d[1]}, 32'h77);
    chk("t4_rx_n", rx_rd_n, 1);
    chk("t4_rdy1_n", rdy1_n, 1);
    chk("t4_rxv_held", {31'd0, rx_v}, 1);
    rxbyte_v = 8'h3C; rx_r = 1'b1;
    @(negedge clk);
    rx_r = 1'b0;
    chk("t4_rxv_clr", {31'd0, rx_v}, 0);
    for (int i = 0; i < 20 && rx_rd_n < 2; i++) @(negedge clk);
    chk("t4_rx_timeout", rx_rd_n, 2);
    chk("t4_rxd2", {24'd0, rx_d}, 32'h3C);
    chk("t4_rxv2", {31'd0, rx_v}, 1);

    // ---------------- waitrequest stall during write
    status_v = 8'h40; tx0_d = 8'h99; tx0_v = 1'b1; rx_r = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && !tx0_r; i++) @(negedge clk);
    chk("t5_rdy_seen", {31'd0, tx0_r}, 1);
    wreq = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tx0_v = 1'b0;
      chk("t5_wr_hold", {31'd0, wr}, 1);
      chk("t5_addr_hold", {27'd0, addr}, 4);
      chk("t5_data_hold", wdata, 32'h99);
      chk("t5_no_rdy", {31'd0, tx0_r}, 0);
    end
    wreq = 1'b0;
    @(negedge clk);
    chk("t5_wr_done", {31'd0, wr}, 0);
    chk("t5_wr_n", wr_n, 1);
    chk("t5_rdy_n", rdy0_n, 1);

    // ---------------- async reset mid-write
    tx1_d = 8'h12; tx1_v = 1'b1; rx_r = 1'b0;
    do_reset();
    for (int i = 0; i < 20 && !tx1_r; i++) @(negedge clk);
    chk("t6_rdy_seen", {31'd0, tx1_r}, 1);
    wreq = 1'b1;
    @(negedge clk);
    chk("t6_wr", {31'd0, wr}, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_wr_drop", {31'd0, wr}, 0);
    chk("t6_rd_drop", {31'd0, rd}, 0);
    chk("t6_addr", {27'd0, addr}, 0);
    chk("t6_wdata", wdata, 0);
    chk("t6_lg", {31'd0, lg}, 1);
    chk("t6_rdy", {30'd0, tx0_r, tx1_r}, 0);
    @(negedge clk);
    rst = 1'b0; wreq = 1'b0;
    @(negedge clk);
    chk("t6_restart_rd", {31'd0, rd}, 1);
    chk("t6_restart_addr", {27'd0, addr}, 8);
    for (int i = 0; i < 20 && wr_n < 1; i++) @(negedge clk);
    tx1_v = 1'b0;
    chk("t6_timeout", {31'd0, wr_n >= 1}, 1);
    chk("t6_byte", {24'd0, wr_d[0]}, 32'h12);
    chk("t6_lg_after", {31'd0, lg}, 1);

    chk("protocol_viol", viol_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
